vr_log_ring_ctrl: RTL and testbench

- Owns head/tail pointers of the VR header log (LOG_HDR_DEPTH entries) and data log (LOG_DEPTH lines of LOG_W bits).
- Serializes three requesters:
  - append: Prepare path allocating an entry.
  - clean: free committed entries up to clean_up_to.
  - truncate: view-change rollback of uncommitted suffix.
- Exports pointers and op bounds into the vr_state register file.
- Reads the header-log RAM through a 1-cycle-latency read port to learn payload extents while cleaning/truncating.

---
 rtl/beehive_vr_pkg.sv | 48 ++++
 rtl/vr_log_ring_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_vr_log_ring_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beehive_vr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// beehive_vr_pkg: ring-pointer types, helpers and log-controller FSM states.
// Revision 1.0
// ----------------------------------------------------------------------------
package beehive_vr_pkg;

  localparam int unsigned VR_HDR_DEPTH  = 4096;
  localparam int unsigned VR_DATA_DEPTH = 2048;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  typedef logic [$clog2(VR_HDR_DEPTH):0]  hdr_ptr_t;
  typedef logic [$clog2(VR_DATA_DEPTH):0] data_ptr_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_APP_RESP = 4'd1,
    ST_CLN_CHK  = 4'd2,
    ST_CLN_WAIT = 4'd3,
    ST_CLN_UPD  = 4'd4,
    ST_TRN_RD   = 4'd5,
    ST_TRN_WAIT = 4'd6,
    ST_TRN_UPD  = 4'd7,
    ST_DONE     = 4'd8
  } vr_log_ctrl_state;

  function automatic logic [31:0] ring_used(input logic [31:0] tail,
                                            input logic [31:0] head,
                                            input int unsigned ptr_w);
    return (tail - head) & ((32'd1 << ptr_w) - 32'd1);
  endfunction

  function automatic logic ring_full(input logic [31:0] tail,
                                     input logic [31:0] head,
                                     input int unsigned ptr_w);
    return ((tail ^ head) & ((32'd1 << ptr_w) - 32'd1)) == (32'd1 << (ptr_w - 1));
  endfunction

  // Widened sum keeps huge lengths from wrapping to a small line count.
  function automatic logic [63:0] lines_for_len(input logic [63:0] len,
                                                input int unsigned lg_line);
    logic [64:0] sum;
    sum = {1'b0, len} + ((65'd1 << lg_line) - 65'd1);
    return 64'(sum >> lg_line);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vr_log_ring_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vr_log_ring_ctrl: owns VR header/data log pointers; serializes append/clean/truncate.
// Revision 1.0
// ----------------------------------------------------------------------------
module vr_log_ring_ctrl
  import beehive_vr_pkg::*;
#(
  parameter int unsigned HDR_DEPTH  = 4096,
  parameter int unsigned DATA_DEPTH = 2048,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned INT_W      = 64,
  localparam int unsigned HA_W      = $clog2(HDR_DEPTH),
  localparam int unsigned DA_W      = $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              app_req_val,
  input  logic [INT_W-1:0]  app_req_op_num,
  input  logic [INT_W-1:0]  app_req_payload_len,
  output logic              app_req_rdy,
  output logic              app_resp_val,
  output logic              app_resp_ok,
  output logic [HA_W-1:0]   app_resp_hdr_addr,
  output logic [DA_W-1:0]   app_resp_data_addr,
  input  logic              app_resp_rdy,
  input  logic              clean_req_val,
  input  logic [INT_W-1:0]  clean_up_to,
  output logic              clean_req_rdy,
  input  logic              trunc_req_val,
  input  logic [INT_W-1:0]  trunc_op,
  output logic              trunc_req_rdy,
  output logic              op_done,
  output logic              hdr_rd_req_val,
  output logic [HA_W-1:0]   hdr_rd_req_addr,
  input  logic [DA_W-1:0]   hdr_rd_resp_payload_addr,
  input  logic [INT_W-1:0]  hdr_rd_resp_payload_len,
  output logic [HA_W:0]     hdr_log_head,
  output logic [HA_W:0]     hdr_log_tail,
  output logic [DA_W:0]     data_log_head,
  output logic [DA_W:0]     data_log_tail,
  output logic [INT_W-1:0]  first_log_op,
  output logic [INT_W-1:0]  last_op
);

  localparam int unsigned LG_LINE = $clog2(LINE_BYTES);
  localparam int unsigned HP_W    = HA_W + 1;
  localparam int unsigned DP_W    = DA_W + 1;

  vr_log_ctrl_state state_q, state_d;

  logic [HA_W:0]      hdr_head_q, hdr_head_d, hdr_tail_q, hdr_tail_d;
  logic [DA_W:0]      data_head_q, data_head_d, data_tail_q, data_tail_d;
  logic [INT_W-1:0]   first_op_q, first_op_d, last_op_q, last_op_d;
  logic [INT_W-1:0]   bound_q, bound_d;
  logic               resp_ok_q, resp_ok_d;
  logic [HA_W-1:0]    resp_hdr_q, resp_hdr_d;
  logic [DA_W-1:0]    resp_data_q, resp_data_d;
  logic [DA_W-1:0]    rd_addr_q, rd_addr_d;
  logic [DA_W:0]      rd_lines_q, rd_lines_d;

  logic [INT_W-1:0]   one_op;
  logic [63:0]        app_lines;
  logic [31:0]        data_used;
  logic [63:0]        data_free;
  logic               hdr_full;
  logic               hdr_empty;
  logic               app_ok;
  logic [HA_W:0]      trn_k;
  logic [DA_W:0]      rd_off;

  assign one_op    = INT_W'(1);
  assign app_lines = lines_for_len(64'(app_req_payload_len), LG_LINE);
  assign data_used = ring_used(32'(data_tail_q), 32'(data_head_q), DP_W);
  assign data_free = 64'(DATA_DEPTH) - 64'(data_used);
  assign hdr_full  = ring_full(32'(hdr_tail_q), 32'(hdr_head_q), HP_W);
  assign hdr_empty = (hdr_tail_q == hdr_head_q);
  assign app_ok    = (app_req_op_num == last_op_q + one_op) && !hdr_full &&
                     (app_lines <= data_free);
  assign trn_k     = HP_W'(bound_q + one_op - first_op_q);
  // Forward distance from the data head to the entry's payload start.
  assign rd_off    = {1'b0, rd_addr_q - data_head_q[DA_W-1:0]};

  always_comb begin
    state_d        = state_q;
    hdr_head_d     = hdr_head_q;
    hdr_tail_d     = hdr_tail_q;
    data_head_d    = data_head_q;
    data_tail_d    = data_tail_q;
    first_op_d     = first_op_q;
    last_op_d      = last_op_q;
    bound_d        = bound_q;
    resp_ok_d      = resp_ok_q;
    resp_hdr_d     = resp_hdr_q;
    resp_data_d    = resp_data_q;
    rd_addr_d      = rd_addr_q;
    rd_lines_d     = rd_lines_q;
    app_req_rdy    = 1'b0;
    clean_req_rdy  = 1'b0;
    trunc_req_rdy  = 1'b0;
    op_done        = 1'b0;
    hdr_rd_req_val = 1'b0;
    hdr_rd_req_addr = hdr_head_q[HA_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (trunc_req_val) begin
          trunc_req_rdy = 1'b1;
          bound_d       = trunc_op;
          state_d       = ST_DONE;
          if (trunc_op >= last_op_q) begin
            state_d = ST_DONE;
          end else if (trunc_op < first_op_q) begin
            hdr_tail_d  = hdr_head_q;
            data_tail_d = data_head_q;
            last_op_d   = first_op_q - one_op;
          end else begin
            state_d = ST_TRN_RD;
          end
        end else if (clean_req_val) begin
          clean_req_rdy = 1'b1;
          bound_d       = clean_up_to;
          state_d       = ST_CLN_CHK;
        end else if (app_req_val) begin
          app_req_rdy = 1'b1;
          resp_ok_d   = app_ok;
          resp_hdr_d  = hdr_tail_q[HA_W-1:0];
          resp_data_d = data_tail_q[DA_W-1:0];
          if (app_ok) begin
            hdr_tail_d  = hdr_tail_q + HP_W'(1);
            data_tail_d = data_tail_q + DP_W'(app_lines);
            last_op_d   = app_req_op_num;
          end
          state_d = ST_APP_RESP;
        end
      end
      ST_APP_RESP: begin
        if (app_resp_rdy) state_d = ST_IDLE;
      end
      ST_CLN_CHK: begin
        if (hdr_empty || (first_op_q > bound_q)) begin
          op_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hdr_rd_req_val = 1'b1;
          state_d        = ST_CLN_WAIT;
        end
      end
      ST_CLN_WAIT: begin
        rd_addr_d  = hdr_rd_resp_payload_addr;
        rd_lines_d = DP_W'(lines_for_len(64'(hdr_rd_resp_payload_len), LG_LINE));
        state_d    = ST_CLN_UPD;
      end
      ST_CLN_UPD: begin
        data_head_d = data_head_q + rd_off + rd_lines_q;
        hdr_head_d  = hdr_head_q + HP_W'(1);
        first_op_d  = first_op_q + one_op;
        state_d     = ST_CLN_CHK;
      end
      ST_TRN_RD: begin
        hdr_rd_req_val  = 1'b1;
        hdr_rd_req_addr = hdr_head_q[HA_W-1:0] + trn_k[HA_W-1:0];
        state_d         = ST_TRN_WAIT;
      end
      ST_TRN_WAIT: begin
        rd_addr_d = hdr_rd_resp_payload_addr;
        state_d   = ST_TRN_UPD;
      end
      ST_TRN_UPD: begin
        // First dropped entry's payload start becomes the new data tail.
        hdr_tail_d  = hdr_head_q + trn_k;
        data_tail_d = data_head_q + rd_off;
        last_op_d   = bound_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_head_q  <= '0;
      hdr_tail_q  <= '0;
      data_head_q <= '0;
      data_tail_q <= '0;
      first_op_q  <= INT_W'(1);
      last_op_q   <= '0;
      bound_q     <= '0;
      resp_ok_q   <= 1'b0;
      resp_hdr_q  <= '0;
      resp_data_q <= '0;
      rd_addr_q   <= '0;
      rd_lines_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_head_q  <= hdr_head_d;
      hdr_tail_q  <= hdr_tail_d;
      data_head_q <= data_head_d;
      data_tail_q <= data_tail_d;
      first_op_q  <= first_op_d;
      last_op_q   <= last_op_d;
      bound_q     <= bound_d;
      resp_ok_q   <= resp_ok_d;
      resp_hdr_q  <= resp_hdr_d;
      resp_data_q <= resp_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_lines_q  <= rd_lines_d;
    end
  end

  assign app_resp_val       = (state_q == ST_APP_RESP);
  assign app_resp_ok        = resp_ok_q;
  assign app_resp_hdr_addr  = resp_hdr_q;
  assign app_resp_data_addr = resp_data_q;
  assign hdr_log_head       = hdr_head_q;
  assign hdr_log_tail       = hdr_tail_q;
  assign data_log_head      = data_head_q;
  assign data_log_tail      = data_tail_q;
  assign first_log_op       = first_op_q;
  assign last_op            = last_op_q;

endmodule
`default_nettype wire

// File: tb/tb_vr_log_ring_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vr_log_ring_ctrl: directed bench with an entry-queue model of both logs.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_vr_log_ring_ctrl;

  localparam int HD  = 4096;
  localparam int DD  = 2048;
  localparam int LB  = 64;
  localparam int IW  = 64;
  localparam int HAW = 12;
  localparam int DAW = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            app_req_val = 1'b0;
  logic [IW-1:0]   app_req_op_num = '0;
  logic [IW-1:0]   app_req_payload_len = '0;
  logic            app_req_rdy;
  logic            app_resp_val;
  logic            app_resp_ok;
  logic [HAW-1:0]  app_resp_hdr_addr;
  logic [DAW-1:0]  app_resp_data_addr;
  logic            app_resp_rdy = 1'b0;
  logic            clean_req_val = 1'b0;
  logic [IW-1:0]   clean_up_to = '0;
  logic            clean_req_rdy;
  logic            trunc_req_val = 1'b0;
  logic [IW-1:0]   trunc_op = '0;
  logic            trunc_req_rdy;
  logic            op_done;
  logic            hdr_rd_req_val;
  logic [HAW-1:0]  hdr_rd_req_addr;
  logic [DAW-1:0]  hdr_rd_resp_payload_addr;
  logic [IW-1:0]   hdr_rd_resp_payload_len;
  logic [HAW:0]    hdr_log_head, hdr_log_tail;
  logic [DAW:0]    data_log_head, data_log_tail;
  logic [IW-1:0]   first_log_op, last_op;

  vr_log_ring_ctrl #(
    .HDR_DEPTH(HD), .DATA_DEPTH(DD), .LINE_BYTES(LB), .INT_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .app_req_val(app_req_val), .app_req_op_num(app_req_op_num),
    .app_req_payload_len(app_req_payload_len), .app_req_rdy(app_req_rdy),
    .app_resp_val(app_resp_val), .app_resp_ok(app_resp_ok),
    .app_resp_hdr_addr(app_resp_hdr_addr), .app_resp_data_addr(app_resp_data_addr),
    .app_resp_rdy(app_resp_rdy),
    .clean_req_val(clean_req_val), .clean_up_to(clean_up_to), .clean_req_rdy(clean_req_rdy),
    .trunc_req_val(trunc_req_val), .trunc_op(trunc_op), .trunc_req_rdy(trunc_req_rdy),
    .op_done(op_done),
    .hdr_rd_req_val(hdr_rd_req_val), .hdr_rd_req_addr(hdr_rd_req_addr),
    .hdr_rd_resp_payload_addr(hdr_rd_resp_payload_addr),
    .hdr_rd_resp_payload_len(hdr_rd_resp_payload_len),
    .hdr_log_head(hdr_log_head), .hdr_log_tail(hdr_log_tail),
    .data_log_head(data_log_head), .data_log_tail(data_log_tail),
    .first_log_op(first_log_op), .last_op(last_op)
  );

  always #5 clk = ~clk;

  // Header-log RAM stand-in: 1-cycle read latency, output holds between reads.
  logic [DAW-1:0] hm_addr [0:HD-1];
  logic [IW-1:0]  hm_len  [0:HD-1];
  always @(posedge clk) begin
    if (hdr_rd_req_val) begin
      hdr_rd_resp_payload_addr <= hm_addr[hdr_rd_req_addr];
      hdr_rd_resp_payload_len  <= hm_len[hdr_rd_req_addr];
    end
  end

  // Model: log is a queue of entries; positions are unbounded counters.
  typedef struct {
    longint unsigned op;
    longint unsigned addr;
    longint unsigned lines;
  } ent_t;
  ent_t            m_q[$];
  longint unsigned m_hhead, m_htail, m_dhead, m_dtail, m_first, m_last;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned m_lines(input longint unsigned len);
    return (len + LB - 1) / LB;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hhead = 0; m_htail = 0; m_dhead = 0; m_dtail = 0;
    m_first = 1; m_last = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("hdr_head",  64'(hdr_log_head),  m_hhead % (2 * HD));
      check("hdr_tail",  64'(hdr_log_tail),  m_htail % (2 * HD));
      check("data_head", 64'(data_log_head), m_dhead % (2 * DD));
      check("data_tail", 64'(data_log_tail), m_dtail % (2 * DD));
      check("first_op",  first_log_op, m_first);
      check("last_op",   last_op, m_last);
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    app_req_val = 1'b0; clean_req_val = 1'b0; trunc_req_val = 1'b0; app_resp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hdr_head",  64'(hdr_log_head), 64'd0);
    check("rst_hdr_tail",  64'(hdr_log_tail), 64'd0);
    check("rst_data_tail", 64'(data_log_tail), 64'd0);
    check("rst_first_op",  first_log_op, 64'd1);
    check("rst_last_op",   last_op, 64'd0);
    check("rst_outs", 64'({app_resp_val, op_done, hdr_rd_req_val}), 64'd0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  task automatic do_append(input longint unsigned op, input longint unsigned len,
                           output bit ok, output logic [63:0] haddr, output logic [63:0] daddr);
    bit              e_ok;
    longint unsigned ln;
    chk_en = 1'b0;
    ln   = m_lines(len);
    e_ok = (op == m_last + 1) && ((m_htail - m_hhead) < HD) && (ln <= DD - (m_dtail - m_dhead));
    app_req_op_num = op; app_req_payload_len = len; app_req_val = 1'b1;
    #1;
    check("app_rdy", 64'(app_req_rdy), 64'd1);
    @(posedge clk); #1;
    app_req_val = 1'b0;
    check("app_resp_val", 64'(app_resp_val), 64'd1);
    check("app_resp_ok", 64'(app_resp_ok), 64'(e_ok));
    check("app_resp_hdr_addr", 64'(app_resp_hdr_addr), m_htail % HD);
    check("app_resp_data_addr", 64'(app_resp_data_addr), m_dtail % DD);
    ok = app_resp_ok; haddr = 64'(app_resp_hdr_addr); daddr = 64'(app_resp_data_addr);
    @(posedge clk); #1;
    check("app_resp_hold", 64'(app_resp_val), 64'd1);
    app_resp_rdy = 1'b1;
    @(posedge clk); #1;
    app_resp_rdy = 1'b0;
    check("app_resp_drop", 64'(app_resp_val), 64'd0);
    if (e_ok) begin
      m_q.push_back('{op: op, addr: m_dtail, lines: ln});
      hm_addr[m_htail % HD] = DAW'(m_dtail % DD);
      hm_len[m_htail % HD]  = len;
      m_htail++;
      m_dtail += ln;
      m_last = op;
    end
    chk_en = 1'b1;
  endtask

  task automatic wait_done(input string nm, output int cycles);
    cycles = 0;
    while (op_done !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({nm, "_done_seen"}, 64'(op_done), 64'd1);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, 64'(op_done), 64'd0);
  endtask

  task automatic do_clean(input longint unsigned up_to, output int cycles);
    chk_en = 1'b0;
    clean_up_to = up_to; clean_req_val = 1'b1;
    #1;
    check("clean_rdy", 64'(clean_req_rdy), 64'd1);
    @(posedge clk); #1;
    clean_req_val = 1'b0;
    wait_done("clean", cycles);
    while (m_q.size() > 0 && m_q[0].op <= up_to) begin
      m_dhead = m_q[0].addr + m_q[0].lines;
      m_hhead++;
      m_first = m_q[0].op + 1;
      void'(m_q.pop_front());
    end
    chk_en = 1'b1;
  endtask

  task automatic do_trunc(input longint unsigned t, output int cycles);
    chk_en = 1'b0;
    trunc_op = t; trunc_req_val = 1'b1;
    #1;
    check("trunc_rdy", 64'(trunc_req_rdy), 64'd1);
    @(posedge clk); #1;
    trunc_req_val = 1'b0;
    wait_done("trunc", cycles);
    if (t < m_last) begin
      if (t < m_first) begin
        m_q.delete();
        m_htail = m_hhead; m_dtail = m_dhead; m_last = m_first - 1;
      end else begin
        while (m_q.size() > 0 && m_q[$].op > t) begin
          m_dtail = m_q[$].addr;
          m_htail--;
          void'(m_q.pop_back());
        end
        m_last = t;
      end
    end
    chk_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [63:0] ha, da;
    int          cyc;

    model_reset();
    do_reset();

    // Basic appends, sequence gaps, zero-length payloads.
    do_append(1, 100, ok, ha, da);
    check("lit_app1_ok", 64'(ok), 64'd1);
    check("lit_app1_haddr", ha, 64'd0);
    check("lit_app1_daddr", da, 64'd0);
    check("lit_app1_dtail", 64'(data_log_tail), 64'd2);
    check("lit_app1_htail", 64'(hdr_log_tail), 64'd1);
    check("lit_app1_last", last_op, 64'd1);
    do_append(3, 64, ok, ha, da);
    check("lit_gap_ok", 64'(ok), 64'd0);
    check("lit_gap_htail", 64'(hdr_log_tail), 64'd1);
    do_append(2, 0, ok, ha, da);
    check("lit_zero_ok", 64'(ok), 64'd1);
    check("lit_zero_dtail", 64'(data_log_tail), 64'd2);

    // Fill the data log to exactly full.
    do_append(3, 2045 * 64, ok, ha, da);
    check("lit_big_dtail", 64'(data_log_tail), 64'd2047);
    do_append(4, 65, ok, ha, da);
    check("lit_over_ok", 64'(ok), 64'd0);
    do_append(4, 1, ok, ha, da);
    check("lit_fill_ok", 64'(ok), 64'd1);
    check("lit_full_dtail", 64'(data_log_tail), 64'h800);

    do_clean(4, cyc);
    check("lit_clean4_cycles", 64'(cyc), 64'd12);
    check("lit_clean4_dhead", 64'(data_log_head), 64'h800);
    do_clean(10, cyc);
    check("lit_clean_empty_cycles", 64'(cyc), 64'd0);

    // Truncate then clean over five single-line entries.
    do_reset();
    for (longint unsigned i = 1; i <= 5; i++) do_append(i, 64, ok, ha, da);
    do_trunc(2, cyc);
    check("lit_trunc2_htail", 64'(hdr_log_tail), 64'd2);
    check("lit_trunc2_dtail", 64'(data_log_tail), 64'd2);
    check("lit_trunc2_last", last_op, 64'd2);
    do_trunc(7, cyc);
    check("lit_trunc_noop_cycles", 64'(cyc), 64'd0);
    for (longint unsigned i = 3; i <= 5; i++) do_append(i, 64, ok, ha, da);
    do_clean(3, cyc);
    check("lit_clean3_cycles", 64'(cyc), 64'd9);
    check("lit_clean3_hhead", 64'(hdr_log_head), 64'd3);
    check("lit_clean3_dhead", 64'(data_log_head), 64'd3);
    check("lit_clean3_first", first_log_op, 64'd4);
    do_trunc(1, cyc);
    check("lit_trunc_empty_htail", 64'(hdr_log_tail), 64'd3);
    check("lit_trunc_empty_last", last_op, 64'd3);

    // Arbitration: trunc beats clean beats append; rdy only in IDLE.
    chk_en = 1'b0;
    trunc_op = 100; clean_up_to = 0; app_req_op_num = 4; app_req_payload_len = 64;
    trunc_req_val = 1'b1; clean_req_val = 1'b1; app_req_val = 1'b1;
    #1;
    check("arb3_trunc_rdy", 64'(trunc_req_rdy), 64'd1);
    check("arb3_clean_rdy", 64'(clean_req_rdy), 64'd0);
    check("arb3_app_rdy", 64'(app_req_rdy), 64'd0);
    @(posedge clk); #1;
    trunc_req_val = 1'b0;
    check("busy_clean_rdy", 64'(clean_req_rdy), 64'd0);
    check("busy_app_rdy", 64'(app_req_rdy), 64'd0);
    clean_req_val = 1'b0; app_req_val = 1'b0;
    wait_done("arb3", cyc);
    clean_req_val = 1'b1; app_req_val = 1'b1;
    #1;
    check("arb2_clean_rdy", 64'(clean_req_rdy), 64'd1);
    check("arb2_app_rdy", 64'(app_req_rdy), 64'd0);
    @(posedge clk); #1;
    clean_req_val = 1'b0; app_req_val = 1'b0;
    wait_done("arb2", cyc);
    check("lit_arb2_cycles", 64'(cyc), 64'd0);
    chk_en = 1'b1;

    // Reset in the middle of a clean read.
    do_append(4, 64, ok, ha, da);
    do_append(5, 64, ok, ha, da);
    chk_en = 1'b0;
    clean_up_to = 10; clean_req_val = 1'b1;
    @(posedge clk); #1;
    clean_req_val = 1'b0;
    check("cln_rd_val", 64'(hdr_rd_req_val), 64'd1);
    check("cln_rd_addr", 64'(hdr_rd_req_addr), 64'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hhead", 64'(hdr_log_head), 64'd0);
    check("mid_rst_htail", 64'(hdr_log_tail), 64'd0);
    check("mid_rst_dhead", 64'(data_log_head), 64'd0);
    check("mid_rst_dtail", 64'(data_log_tail), 64'd0);
    check("mid_rst_first", first_log_op, 64'd1);
    check("mid_rst_last", last_op, 64'd0);
    check("mid_rst_outs", 64'({op_done, hdr_rd_req_val, app_resp_val}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_append(1, 64, ok, ha, da);
    check("lit_post_rst_dtail", 64'(data_log_tail), 64'd1);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
